tx_shift_hold_stuff: RTL and testbench

Parametrised successor to the transmit shift/hold path in the USB transceiver. It holds one word, serialises it one bit per clock, and supports a valid/ready input handshake, selectable bit order and optional USB bit stuffing. It also flags end-of-packet and underrun. It sits between the packet assembler (parallel side) and the NRZI encoder (serial side).

---
 rtl/tx_shift_pkg.sv | 27 ++
 rtl/tx_stuff_ctr.sv | 36 +++
 rtl/tx_shift_hold_stuff.sv | 189 ++++++++++++++++++
 tb/tb_tx_shift_hold_stuff.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_shift_pkg.sv
// Shared types and helpers for the transmit shift/hold path with bit stuffing.
package tx_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } tx_state_e;

  // Width of a counter that indexes DATA_W bits.
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return (data_w <= 1) ? 1 : $clog2(data_w);
  endfunction

  // Width of a counter that must reach STUFF_RUN inclusive.
  function automatic int unsigned run_width(input int unsigned stuff_run);
    return (stuff_run < 1) ? 1 : $clog2(stuff_run + 1);
  endfunction

  // Map the serial bit position onto the parallel word's bit index.
  function automatic int unsigned bit_index(input int unsigned pos,
                                            input int unsigned data_w,
                                            input bit          lsb_first);
    return lsb_first ? pos : (data_w - 1 - pos);
  endfunction

endpackage

// File: rtl/tx_stuff_ctr.sv
// Consecutive-ones counter; flags when a stuff bit must be inserted next.
module tx_stuff_ctr
  import tx_shift_pkg::*;
#(
  parameter int STUFF_RUN = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_vld,
  input  logic bit_val,
  output logic stuff_due
);

  localparam int RUN_W = run_width(STUFF_RUN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_RUN);

  logic [RUN_W-1:0] ones_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (clear) begin
      ones_cnt <= '0;
    end else if (bit_vld) begin
      if (!bit_val) begin
        ones_cnt <= '0;
      end else if (ones_cnt != RUN_MAX) begin
        ones_cnt <= ones_cnt + 1'b1;
      end
    end
  end

  assign stuff_due = (ones_cnt == RUN_MAX);

endmodule

// File: rtl/tx_shift_hold_stuff.sv
// One-word hold register feeding a serialiser with selectable bit order,
// optional USB bit stuffing, end-of-packet and underrun signalling.
module tx_shift_hold_stuff
  import tx_shift_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int STUFF_EN  = 1,
  parameter int STUFF_RUN = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Tx_Data_In,
  input  logic              Tx_Valid,
  input  logic              Tx_Last,
  output logic              Tx_Ready,
  output logic              Tx_Serial_Out,
  output logic              Tx_Serial_En,
  output logic              Tx_Busy,
  output logic              Tx_Eop_Done,
  output logic              Tx_Underrun
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam bit LSB_SEL = (LSB_FIRST != 0);

  logic              hold_full_q;
  logic              hold_last_q;
  logic [DATA_W-1:0] hold_data_q;

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;

  logic              out_q, out_d;
  logic              en_q, en_d;
  logic              eop_q, eop_d;
  logic              udr_q, udr_d;

  logic              accept;
  logic              load;
  logic              word_end;
  logic              ones_clear;
  logic              stuff_due;

  assign Tx_Ready = !hold_full_q;
  assign accept   = Tx_Valid && !hold_full_q;

  // Hold register: accept and load are exclusive because Ready needs an empty hold.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
    end else if (accept) begin
      hold_full_q <= 1'b1;
      hold_last_q <= Tx_Last;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      hold_data_q <= Tx_Data_In;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_d     = word_q;
    last_d     = last_q;
    out_d      = 1'b0;
    en_d       = 1'b0;
    eop_d      = 1'b0;
    udr_d      = 1'b0;
    load       = 1'b0;
    word_end   = 1'b0;
    ones_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (stuff_due) begin
          state_d = STUFF;
          en_d    = 1'b1;
        end else if (bit_cnt_q != LAST_IDX) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          en_d      = 1'b1;
          out_d     = word_q[CNT_W'(bit_index(int'(bit_cnt_d), DATA_W, LSB_SEL))];
        end else begin
          word_end = 1'b1;
        end
      end
      STUFF: begin
        // Stuff bit consumed no data; resume with the next data bit or finish the word.
        if (bit_cnt_q != LAST_IDX) begin
          state_d   = SHIFT;
          bit_cnt_d = bit_cnt_q + 1'b1;
          en_d      = 1'b1;
          out_d     = word_q[CNT_W'(bit_index(int'(bit_cnt_d), DATA_W, LSB_SEL))];
        end else begin
          word_end = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (word_end) begin
      if (last_q) begin
        state_d    = IDLE;
        eop_d      = 1'b1;
        ones_clear = 1'b1;
      end else if (hold_full_q) begin
        load = 1'b1;
      end else begin
        state_d    = IDLE;
        udr_d      = 1'b1;
        ones_clear = 1'b1;
      end
    end

    if (load) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
      word_d    = hold_data_q;
      last_d    = hold_last_q;
      en_d      = 1'b1;
      out_d     = hold_data_q[CNT_W'(bit_index(0, DATA_W, LSB_SEL))];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      out_q     <= 1'b0;
      en_q      <= 1'b0;
      eop_q     <= 1'b0;
      udr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      out_q     <= out_d;
      en_q      <= en_d;
      eop_q     <= eop_d;
      udr_q     <= udr_d;
    end
  end

  always_ff @(posedge Clk) begin
    word_q <= word_d;
  end

  // The run counter sees exactly the bits being presented, stuff bits included.
  if (STUFF_EN != 0) begin : g_stuff
    tx_stuff_ctr #(
      .STUFF_RUN(STUFF_RUN)
    ) u_stuff_ctr (
      .clk      (Clk),
      .rst      (Rst),
      .clear    (ones_clear),
      .bit_vld  (en_d),
      .bit_val  (out_d),
      .stuff_due(stuff_due)
    );
  end else begin : g_no_stuff
    logic unused_stuff;
    assign unused_stuff = ones_clear ^ (STUFF_RUN != 0);
    assign stuff_due    = 1'b0;
  end

  assign Tx_Serial_Out = out_q;
  assign Tx_Serial_En  = en_q;
  assign Tx_Eop_Done   = eop_q;
  assign Tx_Underrun   = udr_q;
  assign Tx_Busy       = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_tx_shift_hold_stuff.sv
// Bench for tx_shift_hold_stuff: LSB-first stuffing instance and MSB-first plain instance.
module tb_tx_shift_hold_stuff;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;

  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0, a_last = 1'b0;
  logic       a_ready, a_so, a_sen, a_busy, a_eop, a_udr;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0, b_last = 1'b0;
  logic       b_ready, b_so, b_sen, b_busy, b_eop, b_udr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit   a_got[$], b_got[$];
  int   a_en[$], b_en[$], a_eopc[$], b_eopc[$], a_udrc[$], b_udrc[$];
  int   a_viol = 0, b_viol = 0;

  logic [7:0] pkt_q[$];
  bit         exp_q[$];

  tx_shift_hold_stuff #(.DATA_W(8), .LSB_FIRST(1), .STUFF_EN(1), .STUFF_RUN(6)) dut_a (
    .Clk(Clk), .Rst(Rst), .Tx_Data_In(a_data), .Tx_Valid(a_valid), .Tx_Last(a_last),
    .Tx_Ready(a_ready), .Tx_Serial_Out(a_so), .Tx_Serial_En(a_sen), .Tx_Busy(a_busy),
    .Tx_Eop_Done(a_eop), .Tx_Underrun(a_udr));

  tx_shift_hold_stuff #(.DATA_W(8), .LSB_FIRST(0), .STUFF_EN(0), .STUFF_RUN(6)) dut_b (
    .Clk(Clk), .Rst(Rst), .Tx_Data_In(b_data), .Tx_Valid(b_valid), .Tx_Last(b_last),
    .Tx_Ready(b_ready), .Tx_Serial_Out(b_so), .Tx_Serial_En(b_sen), .Tx_Busy(b_busy),
    .Tx_Eop_Done(b_eop), .Tx_Underrun(b_udr));

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (a_sen) begin a_got.push_back(a_so); a_en.push_back(cyc); end
    else if (a_so) a_viol++;
    if (a_eop) a_eopc.push_back(cyc);
    if (a_udr) a_udrc.push_back(cyc);
    if (b_sen) begin b_got.push_back(b_so); b_en.push_back(cyc); end
    else if (b_so) b_viol++;
    if (b_eop) b_eopc.push_back(cyc);
    if (b_udr) b_udrc.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete, required completion");
    $fatal(1);
  end

  // Serial line reference: words in chosen order, a 0 inserted after every run of six 1s.
  function automatic void build_expected(input bit lsb, input bit stuff);
    int run;
    bit b;
    exp_q.delete();
    run = 0;
    foreach (pkt_q[w]) begin
      for (int i = 0; i < 8; i++) begin
        b = lsb ? pkt_q[w][i] : pkt_q[w][7-i];
        exp_q.push_back(b);
        run = b ? run + 1 : 0;
        if (stuff && run == 6) begin
          exp_q.push_back(1'b0);
          run = 0;
        end
      end
    end
  endfunction

  function automatic int diff_idx(input int d);
    bit g[$];
    int n;
    if (d == 0) g = a_got; else g = b_got;
    n = (g.size() < exp_q.size()) ? g.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (g[i] !== exp_q[i]) return i;
    if (g.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int span(input int d);
    if (d == 0) return (a_en.size() == 0) ? 0 : a_en[a_en.size()-1] - a_en[0] + 1;
    return (b_en.size() == 0) ? 0 : b_en[b_en.size()-1] - b_en[0] + 1;
  endfunction

  function automatic int got_len(input int d);
    return (d == 0) ? a_got.size() : b_got.size();
  endfunction

  task automatic clear_mon();
    a_got.delete(); a_en.delete(); a_eopc.delete(); a_udrc.delete();
    b_got.delete(); b_en.delete(); b_eopc.delete(); b_udrc.delete();
  endtask

  task automatic push_word(input int d, input logic [7:0] w, input bit l, output int acc);
    int n;
    n = 0;
    if (d == 0) begin a_data = w; a_last = l; a_valid = 1'b1; end
    else        begin b_data = w; b_last = l; b_valid = 1'b1; end
    while (((d == 0) ? !a_ready : !b_ready) && n < 200) begin @(negedge Clk); n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL push_ready dut%0d ready low for %0d cycles, required 1 within 200", d, n);
    end
    acc = cyc + 1;
    @(negedge Clk);
    if (d == 0) a_valid = 1'b0; else b_valid = 1'b0;
  endtask

  task automatic wait_done(input int d, input int nev, input string name);
    int n;
    n = 0;
    while (n < 300 && (((d == 0) ? a_eopc.size() + a_udrc.size()
                                 : b_eopc.size() + b_udrc.size()) < nev)) begin
      @(negedge Clk); n++;
    end
    repeat (2) @(negedge Clk);
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout end events seen fewer than %0d, required %0d", name, nev, nev);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if ({a_so, a_sen, a_busy, a_eop, a_udr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs_a got %b, required 00000", {a_so, a_sen, a_busy, a_eop, a_udr});
    end
    checks++;
    if ({b_so, b_sen, b_busy, b_eop, b_udr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs_b got %b, required 00000", {b_so, b_sen, b_busy, b_eop, b_udr});
    end
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b%b, required 11", a_ready, b_ready);
    end
  endtask

  task automatic test_lsb_basic();
    int acc, di;
    clear_mon();
    pkt_q = '{8'hA5};
    build_expected(1, 1);
    push_word(0, 8'hA5, 1'b1, acc);
    wait_done(0, 1, "a5");
    di = diff_idx(0);
    checks++;
    if (di != -1) begin
      errors++;
      $display("FAIL a5_stream first diff at bit %0d, len got %0d required %0d", di, got_len(0), exp_q.size());
    end
    checks++;
    if (a_en.size() == 0 || a_en[0] != acc + 1) begin
      errors++;
      $display("FAIL a5_latency first bit cycle got %0d, required %0d", (a_en.size() > 0) ? a_en[0] : -1, acc + 1);
    end
    checks++;
    if (a_eopc.size() != 1 || a_en.size() == 0 || a_eopc[0] != a_en[a_en.size()-1] + 1) begin
      errors++;
      $display("FAIL a5_eop pulses got %0d, required 1 on cycle after last bit", a_eopc.size());
    end
    checks++;
    if (a_busy !== 1'b0 || a_udrc.size() != 0) begin
      errors++;
      $display("FAIL a5_idle busy %b underruns %0d, required busy 0 underruns 0", a_busy, a_udrc.size());
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w [3][2];
    int nw [3];
    int acc, di;
    w[0] = '{8'hA5, 8'h00}; nw[0] = 1;
    w[1] = '{8'h01, 8'h00}; nw[1] = 1;
    w[2] = '{8'hFF, 8'hFF}; nw[2] = 2;
    for (int p = 0; p < 3; p++) begin
      clear_mon();
      pkt_q.delete();
      for (int i = 0; i < nw[p]; i++) pkt_q.push_back(w[p][i]);
      build_expected(0, 0);
      for (int i = 0; i < nw[p]; i++) push_word(1, w[p][i], i == nw[p] - 1, acc);
      wait_done(1, 1, "msb");
      di = diff_idx(1);
      checks++;
      if (di != -1) begin
        errors++;
        $display("FAIL msb_stream pkt %0d diff at bit %0d, len got %0d required %0d", p, di, got_len(1), exp_q.size());
      end
      checks++;
      if (b_eopc.size() != 1 || span(1) != exp_q.size()) begin
        errors++;
        $display("FAIL msb_eop pkt %0d eops %0d span %0d, required 1 and %0d", p, b_eopc.size(), span(1), exp_q.size());
      end
    end
  endtask

  task automatic test_stuff();
    logic [7:0] w [3][2];
    int nw [3];
    int acc, di;
    w[0] = '{8'hFF, 8'h00}; nw[0] = 1;
    w[1] = '{8'h3F, 8'hFF}; nw[1] = 2;
    w[2] = '{8'hF0, 8'hFF}; nw[2] = 2;
    for (int p = 0; p < 3; p++) begin
      clear_mon();
      pkt_q.delete();
      for (int i = 0; i < nw[p]; i++) pkt_q.push_back(w[p][i]);
      build_expected(1, 1);
      for (int i = 0; i < nw[p]; i++) push_word(0, w[p][i], i == nw[p] - 1, acc);
      wait_done(0, 1, "stuff");
      di = diff_idx(0);
      checks++;
      if (di != -1) begin
        errors++;
        $display("FAIL stuff_stream pkt %0d diff at bit %0d, len got %0d required %0d", p, di, got_len(0), exp_q.size());
      end
      checks++;
      if (span(0) != exp_q.size() || a_eopc.size() != 1) begin
        errors++;
        $display("FAIL stuff_contig pkt %0d span %0d eops %0d, required %0d and 1", p, span(0), a_eopc.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1, w2;
    int acc, di;
    clear_mon();
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    pkt_q = '{w1, w2};
    build_expected(1, 1);
    push_word(0, w1, 1'b0, acc);
    push_word(0, w2, 1'b1, acc);
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_full got %b, required 0", a_ready);
    end
    a_data = ~w2; a_last = 1'b0; a_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      checks++;
      if (a_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_hold cycle %0d got %b, required 0", i, a_ready);
      end
    end
    a_valid = 1'b0;
    wait_done(0, 1, "b2b");
    di = diff_idx(0);
    checks++;
    if (di != -1) begin
      errors++;
      $display("FAIL b2b_stream diff at bit %0d, len got %0d required %0d", di, got_len(0), exp_q.size());
    end
    checks++;
    if (span(0) != exp_q.size() || exp_q.size() < 16) begin
      errors++;
      $display("FAIL b2b_contig span %0d, required %0d contiguous", span(0), exp_q.size());
    end
  endtask

  task automatic test_packet_gap();
    int acc, di;
    clear_mon();
    pkt_q = '{8'h81, 8'h7E};
    build_expected(1, 1);
    push_word(0, 8'h81, 1'b1, acc);
    push_word(0, 8'h7E, 1'b1, acc);
    wait_done(0, 2, "gap");
    di = diff_idx(0);
    checks++;
    if (di != -1) begin
      errors++;
      $display("FAIL gap_stream diff at bit %0d, len got %0d required %0d", di, got_len(0), exp_q.size());
    end
    checks++;
    if (a_eopc.size() != 2 || a_en.size() < 9 || a_en[8] != a_eopc[0] + 1) begin
      errors++;
      $display("FAIL gap_idle eops %0d second start %0d, required 2 and %0d",
               a_eopc.size(), (a_en.size() > 8) ? a_en[8] : -1, (a_eopc.size() > 0) ? a_eopc[0] + 1 : -1);
    end
  endtask

  task automatic test_underrun();
    int acc, di;
    clear_mon();
    pkt_q = '{8'hFF};
    build_expected(1, 1);
    push_word(0, 8'hFF, 1'b0, acc);
    wait_done(0, 1, "udr");
    di = diff_idx(0);
    checks++;
    if (di != -1) begin
      errors++;
      $display("FAIL udr_stream diff at bit %0d, len got %0d required %0d", di, got_len(0), exp_q.size());
    end
    checks++;
    if (a_udrc.size() != 1 || a_eopc.size() != 0 || a_en.size() == 0 || a_udrc[0] != a_en[a_en.size()-1] + 1) begin
      errors++;
      $display("FAIL udr_pulse underruns %0d eops %0d, required 1 and 0 right after last bit", a_udrc.size(), a_eopc.size());
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL udr_busy got %b, required 0", a_busy);
    end
    clear_mon();
    build_expected(1, 1);
    push_word(0, 8'hFF, 1'b1, acc);
    wait_done(0, 1, "udr_new");
    di = diff_idx(0);
    checks++;
    if (di != -1) begin
      errors++;
      $display("FAIL udr_run_cleared diff at bit %0d, len got %0d required %0d", di, got_len(0), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int acc, di, n;
    clear_mon();
    push_word(0, 8'hFF, 1'b1, acc);
    n = 0;
    while (a_en.size() < 4 && n < 100) begin @(negedge Clk); n++; end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL rstmid_start bits seen %0d, required 4", a_en.size());
    end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({a_so, a_sen, a_busy, a_eop, a_udr} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_async got %b, required 00000", {a_so, a_sen, a_busy, a_eop, a_udr});
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (a_ready !== 1'b1 || a_sen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready ready %b en %b, required 1 and 0", a_ready, a_sen);
    end
    clear_mon();
    pkt_q = '{8'hFF};
    build_expected(1, 1);
    push_word(0, 8'hFF, 1'b1, acc);
    wait_done(0, 1, "rstmid");
    di = diff_idx(0);
    checks++;
    if (di != -1) begin
      errors++;
      $display("FAIL rstmid_stream diff at bit %0d, len got %0d required %0d", di, got_len(0), exp_q.size());
    end
  endtask

  task automatic test_random();
    int acc, di, nw;
    for (int p = 0; p < 10; p++) begin
      clear_mon();
      pkt_q.delete();
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++)
        pkt_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      build_expected(1, 1);
      for (int i = 0; i < nw; i++) push_word(0, pkt_q[i], i == nw - 1, acc);
      wait_done(0, 1, "rand");
      di = diff_idx(0);
      checks++;
      if (di != -1) begin
        errors++;
        $display("FAIL rand_stream pkt %0d diff at bit %0d, len got %0d required %0d", p, di, got_len(0), exp_q.size());
      end
      checks++;
      if (span(0) != exp_q.size() || a_eopc.size() != 1 || a_udrc.size() != 0) begin
        errors++;
        $display("FAIL rand_framing pkt %0d span %0d eops %0d udr %0d, required %0d 1 0",
                 p, span(0), a_eopc.size(), a_udrc.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_idle_output();
    checks++;
    if (a_viol != 0 || b_viol != 0) begin
      errors++;
      $display("FAIL idle_out_zero serial high without enable %0d/%0d times, required 0", a_viol, b_viol);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_msb_first();
    test_stuff();
    test_back_to_back();
    test_packet_gap();
    test_underrun();
    test_reset_mid();
    test_random();
    test_idle_output();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
